wb_queue: RTL and testbench

- In-order writeback queue: the writer side of the dual-file (integer/FP) register file write port.
- Accepts completed results from the execute/memory stages over a valid/ready handshake.
- Buffers up to DEPTH pending writes and drains one per granted cycle onto the register-file write interface (write, fpoint, rw, rs, busW).
- Exposes a pending-destination scoreboard so decode can stall on reads of not-yet-written registers.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/wb_scoreboard_match.sv | 22 ++
 rtl/wb_queue.sv | 142 ++++++++++++++
 tb/tb_wb_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared writeback types: result kinds, queue entry layout and the kind-to-file mapping.
package pipe_pkg;

  localparam int unsigned WB_AW = 5;
  localparam int unsigned WB_DW = 32;

  typedef enum logic [1:0] {
    WB_INT_BUS     = 2'd0,
    WB_FP_FROM_INT = 2'd1,
    WB_INT_FROM_FP = 2'd2,
    WB_FP_BUS      = 2'd3
  } wb_kind_t;

  typedef struct packed {
    wb_kind_t            kind;
    logic [WB_AW-1:0]    rw;
    logic [WB_AW-1:0]    rs;
    logic [WB_DW-1:0]    data;
  } wb_entry_t;

  function automatic logic targets_fp(wb_kind_t k);
    return (k == WB_FP_FROM_INT) || (k == WB_FP_BUS);
  endfunction

endpackage

// File: rtl/wb_scoreboard_match.sv
// Pending-destination comparator array: flags whether any valid entry writes q_reg_i in the queried file.
module wb_scoreboard_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5
) (
  input  logic [DEPTH-1:0]    valid_i,
  input  logic [DEPTH-1:0]    fp_i,
  input  logic [DEPTH*AW-1:0] rw_i,
  input  logic                q_fp_i,
  input  logic [AW-1:0]       q_reg_i,
  output logic                hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && (fp_i[i] == q_fp_i) && (rw_i[i*AW +: AW] == q_reg_i))
        hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue feeding the dual int/FP register-file write port, with a pending-write scoreboard.
// Optional zero-latency bypass of an empty queue is enabled by defining WBQ_BYPASS_EN.
module wb_queue
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_kind,
  input  logic [AW-1:0]              in_rw,
  input  logic [AW-1:0]              in_rs,
  input  logic [DW-1:0]              in_data,
  input  logic                       flush,
  input  logic                       rf_grant,
  output logic                       rf_write,
  output logic [1:0]                 rf_fpoint,
  output logic [AW-1:0]              rf_rw,
  output logic [AW-1:0]              rf_rs,
  output logic [DW-1:0]              rf_busW,
  input  logic                       q_fp,
  input  logic [AW-1:0]              q_rs,
  input  logic [AW-1:0]              q_rt,
  output logic                       q_hazard_a,
  output logic                       q_hazard_b,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_entry_t         mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;

  wb_entry_t         in_ent, head_ent;
  logic              empty, byp, q_push, q_pop;
  logic [DEPTH-1:0]  fp_v;
  logic [DEPTH*AW-1:0] rw_v;
  logic              sb_a, sb_b, byp_fp;

  always_comb begin
    in_ent      = '0;
    in_ent.kind = wb_kind_t'(in_kind);
    in_ent.rw   = in_rw;
    in_ent.rs   = in_rs;
    in_ent.data = in_data;
  end

  assign empty = (count_q == '0);

`ifdef WBQ_BYPASS_EN
  assign byp = empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign rf_write = (!empty || byp) && rf_grant;
  assign q_pop    = rf_write && !empty;
  assign in_ready = !flush && ((count_q < CW'(DEPTH)) || rf_write);
  // A granted bypass consumes the input directly, so it never occupies a slot.
  assign q_push   = in_valid && in_ready && !(byp && rf_grant);

  always_comb begin
    head_ent = '0;
    if (byp)
      head_ent = in_ent;
    else if (!empty)
      head_ent = mem_q[head_q];
  end

  assign rf_fpoint = head_ent.kind;
  assign rf_rw     = head_ent.rw;
  assign rf_rs     = head_ent.rs;
  assign rf_busW   = head_ent.data;
  assign count     = count_q;

  always_comb begin
    fp_v = '0;
    rw_v = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fp_v[i]          = targets_fp(mem_q[i].kind);
      rw_v[i*AW +: AW] = mem_q[i].rw;
    end
  end

  wb_scoreboard_match #(.DEPTH(DEPTH), .AW(AW)) u_match_a (
    .valid_i (valid_q),
    .fp_i    (fp_v),
    .rw_i    (rw_v),
    .q_fp_i  (q_fp),
    .q_reg_i (q_rs),
    .hit_o   (sb_a)
  );

  wb_scoreboard_match #(.DEPTH(DEPTH), .AW(AW)) u_match_b (
    .valid_i (valid_q),
    .fp_i    (fp_v),
    .rw_i    (rw_v),
    .q_fp_i  (q_fp),
    .q_reg_i (q_rt),
    .hit_o   (sb_b)
  );

  assign byp_fp     = targets_fp(in_ent.kind);
  assign q_hazard_a = sb_a || (byp && (byp_fp == q_fp) && (in_rw == q_rs));
  assign q_hazard_b = sb_b || (byp && (byp_fp == q_fp) && (in_rw == q_rt));

  always_ff @(posedge clk) begin
    if (q_push)
      mem_q[tail_q] <= in_ent;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      // Clear before set: on a full push+pop head == tail and the new entry must stay valid.
      if (q_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (q_push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (q_push && !q_pop)
        count_q <= count_q + CW'(1);
      else if (q_pop && !q_push)
        count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DEPTH=4); bypass checks run only when WBQ_BYPASS_EN is defined.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, rf_grant, rf_write;
  logic [1:0]  in_kind, rf_fpoint;
  logic [4:0]  in_rw, in_rs, rf_rw, rf_rs, q_rs, q_rt;
  logic [31:0] in_data, rf_busW;
  logic        q_fp, q_hazard_a, q_hazard_b;
  logic [2:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_rw      (in_rw),
    .in_rs      (in_rs),
    .in_data    (in_data),
    .flush      (flush),
    .rf_grant   (rf_grant),
    .rf_write   (rf_write),
    .rf_fpoint  (rf_fpoint),
    .rf_rw      (rf_rw),
    .rf_rs      (rf_rs),
    .rf_busW    (rf_busW),
    .q_fp       (q_fp),
    .q_rs       (q_rs),
    .q_rt       (q_rt),
    .q_hazard_a (q_hazard_a),
    .q_hazard_b (q_hazard_b),
    .count      (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] k, input logic [4:0] rw, input logic [4:0] rs, input logic [31:0] d);
    in_valid = 1'b1;
    in_kind  = k;
    in_rw    = rw;
    in_rs    = rs;
    in_data  = d;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_kind = 2'd0; in_rw = '0; in_rs = '0; in_data = '0;
    flush = 1'b0; rf_grant = 1'b1; q_fp = 1'b0; q_rs = '0; q_rt = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_haz_a", 32'(q_hazard_a), 32'd0);
    chk("rst_haz_b", 32'(q_hazard_b), 32'd0);
    chk("rst_rf_rw", 32'(rf_rw), 32'd0);
    chk("rst_rf_busW", rf_busW, 32'd0);

    // Single write with grant: presented the cycle after acceptance.
    drive(2'd0, 5'd5, 5'd0, 32'hDEADBEEF);
    #1;
    chk("t1_ready", 32'(in_ready), 32'd1);
`ifdef WBQ_BYPASS_EN
    chk("t1_byp_write", 32'(rf_write), 32'd1);
    chk("t1_byp_rw", 32'(rf_rw), 32'd5);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_byp_count", 32'(count), 32'd0);
`else
    chk("t1_empty_nowrite", 32'(rf_write), 32'd0);
    tick();
    in_valid = 1'b0;
    q_fp = 1'b0; q_rs = 5'd5;
    #1;
    chk("t1_write", 32'(rf_write), 32'd1);
    chk("t1_rw", 32'(rf_rw), 32'd5);
    chk("t1_busW", rf_busW, 32'hDEADBEEF);
    chk("t1_fpoint", 32'(rf_fpoint), 32'd0);
    chk("t1_count1", 32'(count), 32'd1);
    chk("t1_pop_haz", 32'(q_hazard_a), 32'd1);
    tick();
`endif
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_idle_write", 32'(rf_write), 32'd0);

    // Fill with no grant, then drain with a concurrent push on the first drain cycle.
    rf_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 5'(10 + i), 5'd0, 32'h100 + 32'(i));
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("t2_full_count", 32'(count), 32'd4);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    chk("t2_full_nowrite", 32'(rf_write), 32'd0);
    chk("t2_head_rw", 32'(rf_rw), 32'd10);
    rf_grant = 1'b1;
    drive(2'd0, 5'd14, 5'd0, 32'h104);
    #1;
    chk("t2_full_pop_ready", 32'(in_ready), 32'd1);
    chk("t2_drain0_write", 32'(rf_write), 32'd1);
    chk("t2_drain0_busW", rf_busW, 32'h100);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t2_count_hold", 32'(count), 32'd4);
    for (int i = 1; i < 5; i++) begin
      chk("t2_drain_rw", 32'(rf_rw), 32'(10 + i));
      chk("t2_drain_busW", rf_busW, 32'h100 + 32'(i));
      tick();
    end
    chk("t2_drained", 32'(count), 32'd0);

    // Scoreboard file separation.
    rf_grant = 1'b0;
    drive(2'd3, 5'd7, 5'd0, 32'h77);
    tick();
    in_valid = 1'b0;
    q_fp = 1'b1; q_rs = 5'd7; q_rt = 5'd8;
    #1;
    chk("t3_fp_haz_a", 32'(q_hazard_a), 32'd1);
    chk("t3_fp_haz_b", 32'(q_hazard_b), 32'd0);
    chk("t3_fpoint", 32'(rf_fpoint), 32'd3);
    q_fp = 1'b0;
    #1;
    chk("t3_int_haz_a", 32'(q_hazard_a), 32'd0);
    q_fp = 1'b1; q_rt = 5'd7;
    #1;
    chk("t3_fp_haz_b7", 32'(q_hazard_b), 32'd1);

    // Kind 1 (fp <- int[rs]) behind it; pop the kind-3 entry.
    drive(2'd1, 5'd2, 5'd9, 32'h0);
    tick();
    in_valid = 1'b0;
    rf_grant = 1'b1;
    #1;
    chk("t4_pop_write", 32'(rf_write), 32'd1);
    tick();
    rf_grant = 1'b0;
    q_fp = 1'b1; q_rs = 5'd2; q_rt = 5'd7;
    #1;
    chk("t4_fpoint", 32'(rf_fpoint), 32'd1);
    chk("t4_rs", 32'(rf_rs), 32'd9);
    chk("t4_rw", 32'(rf_rw), 32'd2);
    chk("t4_count", 32'(count), 32'd1);
    chk("t4_fp_haz", 32'(q_hazard_a), 32'd1);
    chk("t4_popped_haz", 32'(q_hazard_b), 32'd0);
    q_fp = 1'b0;
    #1;
    chk("t4_int_haz", 32'(q_hazard_a), 32'd0);

    // Flush with three queued and a simultaneous push.
    for (int i = 0; i < 2; i++) begin
      drive(2'd0, 5'(20 + i), 5'd0, 32'h200 + 32'(i));
      tick();
    end
    drive(2'd0, 5'd30, 5'd0, 32'h30);
    flush = 1'b1;
    #1;
    chk("t5_pre_count", 32'(count), 32'd3);
    chk("t5_flush_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; rf_grant = 1'b1;
    q_fp = 1'b0; q_rs = 5'd30; q_rt = 5'd20;
    #1;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_write", 32'(rf_write), 32'd0);
    chk("t5_haz_a", 32'(q_hazard_a), 32'd0);
    chk("t5_haz_b", 32'(q_hazard_b), 32'd0);
    tick();
    chk("t5_never_written", 32'(rf_write), 32'd0);

    // Reset mid-operation discards pending writes.
    rf_grant = 1'b0;
    drive(2'd0, 5'd1, 5'd0, 32'h11);
    tick();
    drive(2'd0, 5'd2, 5'd0, 32'h22);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t6_pre_count", 32'(count), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0; rf_grant = 1'b1;
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_write", 32'(rf_write), 32'd0);
    chk("t6_busW", rf_busW, 32'd0);

`ifdef WBQ_BYPASS_EN
    drive(2'd0, 5'd3, 5'd0, 32'h33);
    q_fp = 1'b0; q_rs = 5'd3;
    #1;
    chk("t7_byp_write", 32'(rf_write), 32'd1);
    chk("t7_byp_rw", 32'(rf_rw), 32'd3);
    chk("t7_byp_busW", rf_busW, 32'h33);
    chk("t7_byp_haz", 32'(q_hazard_a), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t7_byp_count", 32'(count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
